// File: rtl/mc_pred_pack_pkg.sv
// Shared encoder constants for the MC prediction packers.
//   SIZE_08      : write-size code for an 8x8-block row-group word
//   PACK_ZORDER  : block walk in Z (Morton) order
//   PACK_RASTER  : block walk in raster order
//   pack_state_e : packer control states
package mc_pred_pack_pkg;

  localparam logic [1:0] SIZE_08     = 2'd1;
  localparam logic       PACK_ZORDER = 1'b0;
  localparam logic       PACK_RASTER = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pack_state_e;

endpackage

// File: rtl/mc_pred_pack_addr.sv
// Word counter -> 4x4-unit block address mapper (combinational).
//   word  : word counter, bit 0 selects the upper/lower half of an 8x8 block
//   mode  : PACK_ZORDER or PACK_RASTER block walk
//   x_c   : block x in 4x4 units
//   y_c   : block y in 4x4 units
//   idx_c : first row of the word inside its block (0 or ROWS)
module mc_pred_pack_addr
  import mc_pred_pack_pkg::*;
#(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned BLK_LOG = 2
) (
  input  logic [2*BLK_LOG:0] word,
  input  logic               mode,
  output logic [3:0]         x_c,
  output logic [3:0]         y_c,
  output logic [4:0]         idx_c
);

  logic [2*BLK_LOG-1:0] blk;
  logic [3:0]           zx, zy, rx, ry;

  assign blk = word[2*BLK_LOG:1];

  // Bit 0 is always 0 because blocks are 8x8 (two 4x4 units).
  assign zx[0] = 1'b0;
  assign zy[0] = 1'b0;
  assign rx[0] = 1'b0;
  assign ry[0] = 1'b0;

  // Z-order de-interleaves even/odd block bits; raster splits low/high halves.
  for (genvar i = 0; i < 3; i++) begin : g_bit
    if (i < BLK_LOG) begin : g_used
      assign zx[i+1] = blk[2*i];
      assign zy[i+1] = blk[2*i+1];
      assign rx[i+1] = blk[i];
      assign ry[i+1] = blk[BLK_LOG+i];
    end else begin : g_zero
      assign zx[i+1] = 1'b0;
      assign zy[i+1] = 1'b0;
      assign rx[i+1] = 1'b0;
      assign ry[i+1] = 1'b0;
    end
  end

  assign x_c   = (mode == PACK_RASTER) ? rx : zx;
  assign y_c   = (mode == PACK_RASTER) ? ry : zy;
  assign idx_c = word[0] ? 5'(ROWS) : 5'd0;

endmodule

// File: rtl/mc_pred_pack.sv
// Chroma prediction packer: assembles one-hot-lane beats into 8x8 row-group
// words with Z-order/raster addressing and a valid/ready output register.
//   clk, rstn      : clock, synchronous active-low reset
//   start_i        : clear and begin a region (mode_i sampled here)
//   in_ena_i       : one-hot lane select, any bit set offers a beat
//   in_dat_i       : LANES sub-words of SUB_PIX pixels
//   in_rdy_o       : beat accepted when |in_ena_i && in_rdy_o
//   out_ena_o/out_rdy_i : output word handshake
//   out_siz_o, out_4x4_x_o, out_4x4_y_o, out_idx_o, out_dat_o : word + address
//   err_o          : sticky, a non-one-hot beat was consumed
//   done_o         : one-cycle pulse after the last word handshake
module mc_pred_pack
  import mc_pred_pack_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned LANES       = 4,
  parameter int unsigned SUB_PIX     = 4,
  parameter int unsigned ROWS        = 4,
  parameter int unsigned BLK_LOG     = 2
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic                                    start_i,
  input  logic                                    mode_i,
  input  logic [LANES-1:0]                        in_ena_i,
  input  logic [LANES*SUB_PIX*PIXEL_WIDTH-1:0]    in_dat_i,
  output logic                                    in_rdy_o,
  output logic                                    out_ena_o,
  input  logic                                    out_rdy_i,
  output logic [1:0]                              out_siz_o,
  output logic [3:0]                              out_4x4_x_o,
  output logic [3:0]                              out_4x4_y_o,
  output logic [4:0]                              out_idx_o,
  output logic [2*ROWS*SUB_PIX*PIXEL_WIDTH-1:0]   out_dat_o,
  output logic                                    err_o,
  output logic                                    done_o
);

  localparam int unsigned SW          = SUB_PIX * PIXEL_WIDTH;
  localparam int unsigned BEATS       = 2 * ROWS;
  localparam int unsigned WORD_W      = BEATS * SW;
  localparam int unsigned TOTAL_WORDS = 2 << (2 * BLK_LOG);
  localparam int unsigned WCNT_W      = 2 * BLK_LOG + 1;
  localparam int unsigned BCNT_W      = $clog2(BEATS);

  pack_state_e             state_q, state_d;
  logic [BCNT_W-1:0]       beat_q;
  logic [WCNT_W-1:0]       word_q;
  logic [WORD_W-1:0]       asm_q, asm_c;
  logic                    mode_q;
  logic [SW-1:0]           beat_dat_c;
  logic [SW-1:0][LANES-1:0] lane_bits;
  logic                    rdy_c, onehot_c, take_c, bad_c;
  logic                    last_beat_c, last_word_c, out_hs_c;
  logic [3:0]              x_c, y_c;
  logic [4:0]              idx_c;

  // Handshake qualifiers; a beat offered alongside start_i is refused.
  assign rdy_c       = (state_q == ST_RUN) && !start_i && (!out_ena_o || out_rdy_i);
  assign in_rdy_o    = rdy_c;
  assign onehot_c    = (in_ena_i != '0) && ((in_ena_i & (in_ena_i - LANES'(1))) == '0);
  assign take_c      = rdy_c && onehot_c;
  assign bad_c       = rdy_c && (in_ena_i != '0) && !onehot_c;
  assign out_hs_c    = out_ena_o && out_rdy_i;
  assign last_beat_c = (beat_q == BCNT_W'(BEATS - 1));
  assign last_word_c = (word_q == WCNT_W'(TOTAL_WORDS - 1));
  assign out_siz_o   = SIZE_08;

  // AND-OR lane mux, valid because the selected beat is one-hot.
  for (genvar k = 0; k < SW; k++) begin : g_pix_bit
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign lane_bits[k][j] = in_ena_i[j] & in_dat_i[j*SW + k];
    end
    assign beat_dat_c[k] = |lane_bits[k];
  end

  // Slot s = 2*row + half, MSB-first: slot s is filled by beat half*ROWS+row.
  for (genvar s = 0; s < BEATS; s++) begin : g_slot
    localparam int unsigned BEAT_OF_SLOT = (s % 2) * ROWS + s / 2;
    assign asm_c[(BEATS-1-s)*SW +: SW] =
      (take_c && beat_q == BCNT_W'(BEAT_OF_SLOT)) ? beat_dat_c
                                                  : asm_q[(BEATS-1-s)*SW +: SW];
  end

  mc_pred_pack_addr #(
    .ROWS    (ROWS),
    .BLK_LOG (BLK_LOG)
  ) u_addr (
    .word  (word_q),
    .mode  (mode_q),
    .x_c   (x_c),
    .y_c   (y_c),
    .idx_c (idx_c)
  );

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (take_c && last_beat_c && last_word_c) state_d = ST_DRAIN;
      ST_DRAIN: if (out_hs_c) state_d = ST_IDLE;
      default:  state_d = state_q;
    endcase
    if (start_i) state_d = ST_RUN;
  end

  // Assembly buffer, counters and output word register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_q      <= '0;
      word_q      <= '0;
      asm_q       <= '0;
      mode_q      <= 1'b0;
      out_ena_o   <= 1'b0;
      out_dat_o   <= '0;
      out_4x4_x_o <= '0;
      out_4x4_y_o <= '0;
      out_idx_o   <= '0;
      err_o       <= 1'b0;
      done_o      <= 1'b0;
    end else if (start_i) begin
      beat_q    <= '0;
      word_q    <= '0;
      asm_q     <= '0;
      mode_q    <= mode_i;
      out_ena_o <= 1'b0;
      err_o     <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= (state_q == ST_DRAIN) && out_hs_c;
      if (bad_c) err_o <= 1'b1;
      if (take_c) begin
        if (last_beat_c) begin
          // Load completes the word; any concurrent handshake is superseded.
          beat_q      <= '0;
          asm_q       <= '0;
          word_q      <= word_q + WCNT_W'(1);
          out_dat_o   <= asm_c;
          out_ena_o   <= 1'b1;
          out_4x4_x_o <= x_c;
          out_4x4_y_o <= y_c;
          out_idx_o   <= idx_c;
        end else begin
          beat_q <= beat_q + BCNT_W'(1);
          asm_q  <= asm_c;
          if (out_hs_c) out_ena_o <= 1'b0;
        end
      end else if (out_hs_c) begin
        out_ena_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc_pred_pack.sv
// Randomized self-checking bench for mc_pred_pack against a word-level model.
module tb_mc_pred_pack;
  import mc_pred_pack_pkg::*;

  localparam int unsigned PW    = 8;
  localparam int unsigned LN    = 4;
  localparam int unsigned SP    = 4;
  localparam int unsigned RW    = 4;
  localparam int unsigned BL    = 2;
  localparam int unsigned SW    = SP * PW;
  localparam int unsigned BEATS = 2 * RW;
  localparam int unsigned WW    = BEATS * SW;
  localparam int unsigned DW    = LN * SW;
  localparam int unsigned TOTAL = 2 * (4 ** BL);

  logic          clk, rstn, start_i, mode_i, out_rdy_i;
  logic [LN-1:0] in_ena_i;
  logic [DW-1:0] in_dat_i;
  logic          in_rdy_o, out_ena_o, err_o, done_o;
  logic [1:0]    out_siz_o;
  logic [3:0]    out_4x4_x_o, out_4x4_y_o;
  logic [4:0]    out_idx_o;
  logic [WW-1:0] out_dat_o;

  mc_pred_pack #(
    .PIXEL_WIDTH (PW), .LANES (LN), .SUB_PIX (SP), .ROWS (RW), .BLK_LOG (BL)
  ) dut (
    .clk (clk), .rstn (rstn), .start_i (start_i), .mode_i (mode_i),
    .in_ena_i (in_ena_i), .in_dat_i (in_dat_i), .in_rdy_o (in_rdy_o),
    .out_ena_o (out_ena_o), .out_rdy_i (out_rdy_i), .out_siz_o (out_siz_o),
    .out_4x4_x_o (out_4x4_x_o), .out_4x4_y_o (out_4x4_y_o),
    .out_idx_o (out_idx_o), .out_dat_o (out_dat_o),
    .err_o (err_o), .done_o (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: region progress, sticky error and the output word register.
  bit            m_run, m_drain, m_mode, m_ena, m_err, m_done, last_acc;
  int            m_beat, m_word, m_x, m_y, m_idx, done_seen;
  logic [WW-1:0] m_buf, m_dat;

  task automatic ref_addr(input int w, input bit md, output int x, output int y, output int idx);
    int blk;
    blk = w / 2;
    idx = (w % 2) * RW;
    x = 0;
    y = 0;
    if (md) begin
      x = 2 * (blk % (1 << BL));
      y = 2 * (blk / (1 << BL));
    end else begin
      for (int i = 0; i < BL; i++) begin
        x += ((blk >> (2 * i)) & 1) << (i + 1);
        y += ((blk >> (2 * i + 1)) & 1) << (i + 1);
      end
    end
  endtask

  function automatic logic [DW-1:0] mk_dat(input int lane, input logic [SW-1:0] v);
    logic [DW-1:0] d;
    logic [DW-1:0] mask;
    d = '0;
    for (int j = 0; j < LN; j++) d = (d << SW) | DW'(SW'($urandom));
    mask = ~(DW'({SW{1'b1}}) << (lane * SW));
    return (d & mask) | (DW'(v) << (lane * SW));
  endfunction

  // One clock: drive at negedge, check in_rdy, update model at posedge, check outputs.
  task automatic cyc(input bit st, input bit md, input logic [LN-1:0] ena,
                     input logic [DW-1:0] dat, input bit ordy);
    bit            exp_rdy, hs;
    int            lane, s;
    logic [SW-1:0] lw;
    start_i = st; mode_i = md; in_ena_i = ena; in_dat_i = dat; out_rdy_i = ordy;
    #1;
    exp_rdy = !st && m_run && (!m_ena || ordy);
    check("in_rdy", WW'(in_rdy_o), WW'(exp_rdy));
    last_acc = 0;
    @(posedge clk);
    if (st) begin
      m_run = 1; m_drain = 0; m_beat = 0; m_word = 0; m_buf = '0;
      m_ena = 0; m_err = 0; m_done = 0; m_mode = md;
    end else begin
      hs = m_ena && ordy;
      m_done = m_drain && hs;
      if (m_done) m_drain = 0;
      if (hs) m_ena = 0;
      if (ena != '0 && exp_rdy) begin
        if ($countones(ena) != 1) m_err = 1;
        else begin
          last_acc = 1;
          lane = 0;
          for (int j = 0; j < LN; j++) if (((ena >> j) & LN'(1)) != '0) lane = j;
          lw = SW'(dat >> (lane * SW));
          s = 2 * (m_beat % RW) + m_beat / RW;
          m_buf = m_buf | (WW'(lw) << ((BEATS - 1 - s) * SW));
          m_beat++;
          if (m_beat == BEATS) begin
            m_dat = m_buf;
            m_ena = 1;
            ref_addr(m_word, m_mode, m_x, m_y, m_idx);
            m_word++;
            m_beat = 0;
            m_buf = '0;
            if (m_word == TOTAL) begin m_run = 0; m_drain = 1; end
          end
        end
      end
    end
    @(negedge clk);
    check("out_ena", WW'(out_ena_o), WW'(m_ena));
    check("err", WW'(err_o), WW'(m_err));
    check("done", WW'(done_o), WW'(m_done));
    check("siz", WW'(out_siz_o), WW'(2'd1));
    if (m_ena) begin
      check("dat", out_dat_o, m_dat);
      check("x", WW'(out_4x4_x_o), WW'(m_x));
      check("y", WW'(out_4x4_y_o), WW'(m_y));
      check("idx", WW'(out_idx_o), WW'(m_idx));
    end
    if (done_o) done_seen++;
  endtask

  // Offer beat n (pixels = n, lane = n mod LN) until taken, bounded.
  task automatic beat(input int n, input int pct);
    int c;
    c = 0;
    last_acc = 0;
    while (!last_acc && c < 60) begin
      cyc(0, m_mode, LN'(1) << (n % LN), mk_dat(n % LN, {SP{8'(n)}}),
          int'($urandom_range(0, 99)) < pct);
      c++;
    end
    check($sformatf("beat%0d_taken", n), WW'(last_acc), WW'(1));
  endtask

  task automatic do_start(input bit md, input bit ordy);
    cyc(1, md, LN'($urandom_range(1, 15)), mk_dat(0, SW'($urandom)), ordy);
  endtask

  task automatic do_reset(input int n);
    rstn = 0; start_i = 0; mode_i = 0; out_rdy_i = 1;
    in_ena_i = LN'(1); in_dat_i = mk_dat(0, SW'($urandom));
    repeat (n) @(posedge clk);
    @(negedge clk);
    m_run = 0; m_drain = 0; m_mode = 0; m_ena = 0; m_err = 0; m_done = 0;
    m_beat = 0; m_word = 0; m_buf = '0; m_dat = '0; m_x = 0; m_y = 0; m_idx = 0;
    check("rst_ena", WW'(out_ena_o), WW'(0));
    check("rst_dat", out_dat_o, WW'(0));
    check("rst_x", WW'(out_4x4_x_o), WW'(0));
    check("rst_y", WW'(out_4x4_y_o), WW'(0));
    check("rst_idx", WW'(out_idx_o), WW'(0));
    check("rst_err", WW'(err_o), WW'(0));
    check("rst_done", WW'(done_o), WW'(0));
    check("rst_rdy", WW'(in_rdy_o), WW'(0));
    rstn = 1;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_seen == 0 && k < 20) begin
      cyc(0, m_mode, '0, '0, 1);
      k++;
    end
    check(tag, WW'(done_seen), WW'(1));
  endtask

  initial begin
    bit w8_seen, w6_seen;
    logic [WW-1:0] cap_dat;
    logic [LN-1:0] ena;
    int r, lane;

    do_reset(3);

    // Full Z-order region at full throughput.
    done_seen = 0;
    do_start(PACK_ZORDER, 1);
    for (int n = 0; n < int'(TOTAL * BEATS); n++) begin
      beat(n, 100);
      if (n == 7) begin
        check("w0_row0_left", WW'(out_dat_o[WW-1 -: SW]), WW'(32'h00000000));
        check("w0_row0_right", WW'(out_dat_o[WW-SW-1 -: SW]), WW'(32'h04040404));
        check("w0_row1_left", WW'(out_dat_o[WW-2*SW-1 -: SW]), WW'(32'h01010101));
        check("w0_row3_right", WW'(out_dat_o[SW-1:0]), WW'(32'h07070707));
        check("w0_addr", WW'({out_4x4_x_o, out_4x4_y_o, out_idx_o}), WW'(13'h0));
      end
      if (n == 15) check("w1_addr", WW'({out_4x4_x_o, out_4x4_y_o, out_idx_o}), WW'({4'd0, 4'd0, 5'd4}));
      if (n == 23) check("w2_addr", WW'({out_4x4_x_o, out_4x4_y_o, out_idx_o}), WW'({4'd2, 4'd0, 5'd0}));
      if (n == 39) check("w4_addr", WW'({out_4x4_x_o, out_4x4_y_o, out_idx_o}), WW'({4'd0, 4'd2, 5'd0}));
    end
    wait_done("zorder_done");

    // Raster region with random gaps, back-pressure and occasional bad beats.
    done_seen = 0;
    w8_seen = 0;
    w6_seen = 0;
    do_start(PACK_RASTER, 1);
    for (int c = 0; c < 8000 && done_seen == 0; c++) begin
      r = int'($urandom_range(0, 99));
      lane = int'($urandom_range(0, LN - 1));
      if (r < 75)      ena = LN'(1) << lane;
      else if (r < 95) ena = '0;
      else             ena = LN'(3) << $urandom_range(0, LN - 2);
      cyc(0, m_mode, ena, mk_dat(lane, SW'($urandom)), $urandom_range(0, 99) < 70);
      if (m_ena && m_word == 9 && !w8_seen) begin
        w8_seen = 1;
        check("r_w8_addr", WW'({out_4x4_x_o, out_4x4_y_o, out_idx_o}), WW'({4'd0, 4'd2, 5'd0}));
      end
      if (m_ena && m_word == 7 && !w6_seen) begin
        w6_seen = 1;
        check("r_w6_addr", WW'({out_4x4_x_o, out_4x4_y_o, out_idx_o}), WW'({4'd6, 4'd0, 5'd0}));
      end
    end
    check("raster_done", WW'(done_seen), WW'(1));
    check("raster_w8_w6_seen", WW'({w8_seen, w6_seen}), WW'(2'b11));

    // Output held under back-pressure; no beat lost after release.
    do_start(PACK_ZORDER, 1);
    for (int n = 0; n < 8; n++) beat(n, 100);
    cap_dat = out_dat_o;
    for (int c = 0; c < 20; c++) begin
      cyc(0, m_mode, LN'(1), mk_dat(0, {SP{8'd8}}), 0);
      check("hold_dat", out_dat_o, cap_dat);
      check("hold_ena", WW'(out_ena_o), WW'(1));
      check("hold_no_take", WW'(last_acc), WW'(0));
    end
    for (int n = 8; n < 64; n++) beat(n, (n < 24) ? 100 : 50);

    // Non-one-hot beat: dropped, sticky error, cleared by start.
    do_start(PACK_ZORDER, 1);
    for (int n = 0; n < 3; n++) beat(n, 100);
    cyc(0, m_mode, 4'b0101, mk_dat(0, 32'hdeadbeef), 1);
    check("err_set", WW'(err_o), WW'(1));
    for (int n = 3; n < 8; n++) beat(n, 100);
    check("err_beat3_slot", WW'(out_dat_o[2*SW-1 -: SW]), WW'(32'h03030303));
    check("err_sticky", WW'(err_o), WW'(1));
    do_start(PACK_ZORDER, 1);
    check("err_cleared", WW'(err_o), WW'(0));

    // Restart mid-region: partial and pending words discarded, no done.
    done_seen = 0;
    for (int n = 0; n < 13; n++) beat(n, 100);
    do_start(PACK_ZORDER, 0);
    for (int n = 0; n < 8; n++) beat(n, 100);
    check("restart_addr", WW'({out_4x4_x_o, out_4x4_y_o, out_idx_o}), WW'(13'h0));
    cyc(0, m_mode, '0, '0, 0);
    do_start(PACK_ZORDER, 0);
    check("restart_drop_ena", WW'(out_ena_o), WW'(0));
    for (int n = 0; n < 8; n++) beat(n, 100);
    check("restart_addr2", WW'({out_4x4_x_o, out_4x4_y_o, out_idx_o}), WW'(13'h0));
    check("restart_no_done", WW'(done_seen), WW'(0));

    // Reset while draining the final word.
    done_seen = 0;
    do_start(PACK_RASTER, 1);
    for (int n = 0; n < int'(TOTAL * BEATS); n++) beat(n, 100);
    for (int c = 0; c < 3; c++) cyc(0, m_mode, '0, '0, 0);
    check("drain_hold", WW'(out_ena_o), WW'(1));
    do_reset(1);
    for (int c = 0; c < 5; c++) begin
      cyc(0, 0, LN'(1) << (c % LN), mk_dat(c % LN, SW'($urandom)), 1);
      check("post_rst_refused", WW'(last_acc), WW'(0));
    end
    check("post_rst_no_done", WW'(done_seen), WW'(0));
    do_start(PACK_ZORDER, 1);
    for (int n = 0; n < 8; n++) beat(n, 100);
    check("post_rst_addr", WW'({out_4x4_x_o, out_4x4_y_o, out_idx_o}), WW'(13'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
